// File: rtl/ingress_port_requester.sv
// Per-ingress-port front end: reads the destination mask from the header beat,
// requests the arbiter, then streams the packet into the crossbar or drains it.
module ingress_port_requester #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  port_req,
  output logic [ADDR_WIDTH-1:0] port_dst,
  input  logic                  grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_eop,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  timeout_cnt,
  output logic                  stray_err
);

  localparam int WAIT_W = (REQ_TIMEOUT > 0) ? $clog2(REQ_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(REQ_TIMEOUT - 1);
  localparam bit TMO_EN = (REQ_TIMEOUT > 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] dst_r, dst_s;
  logic [WAIT_W-1:0]     wait_r, wait_s;
  logic [CNT_WIDTH-1:0]  pkt_cnt_r, drop_cnt_r, timeout_cnt_r;
  logic                  pkt_inc_s, drop_inc_s, tmo_inc_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  // Next-state and handshake decode; everything is held quiet while reset is asserted
  always_comb begin
    state_s    = state_r;
    dst_s      = dst_r;
    wait_s     = wait_r;
    in_ready   = 1'b0;
    port_req   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_eop    = 1'b0;
    stray_err  = 1'b0;
    pkt_inc_s  = 1'b0;
    drop_inc_s = 1'b0;
    tmo_inc_s  = 1'b0;
    if (rst_n) begin
      case (state_r)
        ST_IDLE: begin
          // Header is only peeked here; it is consumed later by SEND or DROP
          if (in_valid && in_sop) begin
            dst_s  = in_data[ADDR_WIDTH-1:0];
            wait_s = '0;
            if (|in_data[ADDR_WIDTH-1:0]) begin
              state_s = ST_REQ;
            end else begin
              state_s = ST_DROP;
            end
          end else if (in_valid) begin
            in_ready  = 1'b1;
            stray_err = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          port_req = 1'b1;
          if (grant) begin
            state_s = ST_SEND;
          end else if (TMO_EN && (wait_r == WAIT_LAST)) begin
            state_s   = ST_DROP;
            tmo_inc_s = 1'b1;
          end else begin
            wait_s = wait_r + WAIT_W'(1);
          end
        end
        ST_SEND: begin
          out_valid = in_valid;
          in_ready  = out_ready;
          out_data  = in_data;
          out_eop   = in_eop;
          if (in_valid && out_ready && in_eop) begin
            state_s   = ST_IDLE;
            pkt_inc_s = 1'b1;
          end else begin
            state_s = ST_SEND;
          end
        end
        ST_DROP: begin
          in_ready = 1'b1;
          if (in_valid && in_eop) begin
            state_s    = ST_IDLE;
            drop_inc_s = 1'b1;
          end else begin
            state_s = ST_DROP;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = ST_IDLE;
    end
  end

  // FSM, latched destination mask and REQ wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      dst_r   <= '0;
      wait_r  <= '0;
    end else begin
      state_r <= state_s;
      dst_r   <= dst_s;
      wait_r  <= wait_s;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_r     <= '0;
      drop_cnt_r    <= '0;
      timeout_cnt_r <= '0;
    end else begin
      if (pkt_inc_s)  pkt_cnt_r     <= sat_inc(pkt_cnt_r);
      if (drop_inc_s) drop_cnt_r    <= sat_inc(drop_cnt_r);
      if (tmo_inc_s)  timeout_cnt_r <= sat_inc(timeout_cnt_r);
    end
  end

  assign port_dst    = dst_r;
  assign pkt_cnt     = pkt_cnt_r;
  assign drop_cnt    = drop_cnt_r;
  assign timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_ingress_port_requester.sv
// Bench for ingress_port_requester: a queue-based ingress FIFO and arbiter model drive
// random packets; forwarded beats and counters are checked against packet-level rules.
module tb_ingress_port_requester;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int T  = 4;
  localparam int CMAX = 15;

  logic clk, rst_n;
  logic in_valid, in_ready, in_sop, in_eop;
  logic [DW-1:0] in_data, out_data;
  logic port_req, grant, out_valid, out_ready, out_eop, stray_err;
  logic [AW-1:0] port_dst;
  logic [CW-1:0] pkt_cnt, drop_cnt, timeout_cnt;

  ingress_port_requester #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .REQ_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .port_req(port_req), .port_dst(port_dst), .grant(grant),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eop(out_eop),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt), .stray_err(stray_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic sop; logic eop; } beat_t;
  beat_t fifo_q[$];
  logic [DW:0] exp_q[$];
  logic [DW:0] obs_q[$];
  int req_rise_q[$];
  int eop_cyc_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  int gdelay = 0, req_run = 0, ordy_mode = 0;
  bit gaps = 1'b0, spur = 1'b0, in_send = 1'b0;
  logic prev_req = 1'b0;
  int req_cycles, stray_pulses, ov_cycles, rdy_mismatch, cyc_grant, cyc_first_ov;
  logic [AW-1:0] dst_or, dst_and;
  int exp_pkt = 0, exp_drop = 0, exp_tmo = 0;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic drive_inputs();
    if (fifo_q.size() > 0 && (!gaps || $urandom_range(3, 0) != 0)) begin
      in_valid = 1'b1;
      in_data  = fifo_q[0].d;
      in_sop   = fifo_q[0].sop;
      in_eop   = fifo_q[0].eop;
    end else begin
      in_valid = 1'b0;
      in_data  = $urandom;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
    end
    case (ordy_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(1, 0));
      default: out_ready = 1'b1;
    endcase
    if (port_req) grant = (req_run == gdelay);
    else          grant = spur ? 1'($urandom_range(1, 0)) : 1'b0;
  endtask

  // One clock: observe at the falling edge, retire the FIFO head on handshake, redrive.
  task automatic step();
    bit hs_in;
    @(negedge clk);
    cyc++;
    hs_in = in_valid & in_ready;
    if (port_req) begin
      req_cycles++;
      dst_or  = dst_or | port_dst;
      dst_and = dst_and & port_dst;
      if (!prev_req) req_rise_q.push_back(cyc);
    end
    prev_req = port_req;
    if (stray_err) stray_pulses++;
    if (out_valid) begin
      ov_cycles++;
      if (cyc_first_ov < 0) cyc_first_ov = cyc;
    end
    if (in_send && (in_ready !== out_ready)) rdy_mismatch++;
    if (out_valid && out_ready) begin
      obs_q.push_back({out_eop, out_data});
      if (out_eop) begin
        eop_cyc_q.push_back(cyc);
        in_send = 1'b0;
      end
    end
    if (port_req && grant) begin
      cyc_grant = cyc;
      in_send   = 1'b1;
    end
    if (port_req && !grant) req_run++;
    else req_run = 0;
    @(posedge clk);
    #1;
    if (hs_in) void'(fifo_q.pop_front());
    drive_inputs();
  endtask

  task automatic clear_mon();
    req_cycles = 0; stray_pulses = 0; ov_cycles = 0; rdy_mismatch = 0;
    cyc_grant = -1; cyc_first_ov = -1;
    dst_or = '0; dst_and = '1;
    obs_q.delete(); exp_q.delete(); req_rise_q.delete(); eop_cyc_q.delete();
  endtask

  // Queue a packet; the model decides its fate from mask and the arbiter's grant delay.
  task automatic push_packet(input logic [AW-1:0] mask, input int nbeats, input bit model);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.d = $urandom;
      if (i == 0) b.d[AW-1:0] = mask;
      b.sop = (i == 0);
      b.eop = (i == nbeats - 1);
      fifo_q.push_back(b);
      if (model && mask != '0 && gdelay < T) exp_q.push_back({b.eop, b.d});
    end
    if (model) begin
      if (mask == '0) exp_drop = sat(exp_drop + 1);
      else if (gdelay >= T) begin
        exp_tmo  = sat(exp_tmo + 1);
        exp_drop = sat(exp_drop + 1);
      end else exp_pkt = sat(exp_pkt + 1);
    end
    drive_inputs();
  endtask

  task automatic run_until_empty(input int limit);
    int k = 0;
    while (fifo_q.size() > 0 && k < limit) begin
      step();
      k++;
    end
    step();
    step();
    n_checks++;
    if (fifo_q.size() != 0) $display("FAIL drain_bound: %0d beats left after %0d cycles, want 0", fifo_q.size(), limit);
    else n_pass++;
  endtask

  task automatic compare_stream(input string name);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL %s_len: got %0d beats want %0d", name, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL %s_beat%0d: got %h want %h", name, i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; grant = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = $urandom;
    #12;
    n_checks++;
    if ({port_req, port_dst, out_valid, in_ready, out_eop, stray_err, pkt_cnt, drop_cnt, timeout_cnt} !== '0)
      $display("FAIL reset_outputs: got %b want all zero",
               {port_req, port_dst, out_valid, in_ready, out_eop, stray_err, pkt_cnt, drop_cnt, timeout_cnt});
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_inputs();
    clear_mon();
    step();
    n_checks++;
    if ({port_req, out_valid, stray_pulses != 0} !== 3'b000) $display("FAIL post_reset_idle: req=%b ov=%b strays=%0d want 0/0/0", port_req, out_valid, stray_pulses);
    else n_pass++;
  endtask

  task automatic test_unicast();
    int c0;
    clear_mon(); gaps = 1'b0; ordy_mode = 0; gdelay = 2;
    push_packet(4'b0100, 4, 1'b1);
    c0 = cyc + 1;
    run_until_empty(100);
    n_checks++;
    if ({dst_or, dst_and} !== {4'b0100, 4'b0100}) $display("FAIL uni_dst: or=%b and=%b want 0100", dst_or, dst_and);
    else n_pass++;
    n_checks++;
    if (req_cycles !== 3) $display("FAIL uni_req_cycles: got %0d want 3", req_cycles);
    else n_pass++;
    n_checks++;
    if (req_rise_q.size() == 0 || req_rise_q[0] !== c0 + 1) $display("FAIL uni_req_latency: got %0d want %0d", (req_rise_q.size() == 0) ? -1 : req_rise_q[0], c0 + 1);
    else n_pass++;
    n_checks++;
    if (cyc_first_ov !== cyc_grant + 1) $display("FAIL uni_send_latency: got %0d want %0d", cyc_first_ov, cyc_grant + 1);
    else n_pass++;
    compare_stream("uni");
    n_checks++;
    if (pkt_cnt !== CW'(exp_pkt) || port_req !== 1'b0) $display("FAIL uni_pkt_cnt: got %0d req=%b want %0d req=0", pkt_cnt, port_req, exp_pkt);
    else n_pass++;
  endtask

  task automatic test_multicast();
    clear_mon(); gaps = 1'b0; ordy_mode = 1; gdelay = $urandom_range(2, 0);
    push_packet(4'b1011, 6, 1'b1);
    run_until_empty(100);
    ordy_mode = 0;
    compare_stream("mc");
    n_checks++;
    if (rdy_mismatch !== 0) $display("FAIL mc_ready_track: got %0d mismatching cycles want 0", rdy_mismatch);
    else n_pass++;
    n_checks++;
    if (pkt_cnt !== CW'(exp_pkt)) $display("FAIL mc_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
    else n_pass++;
  endtask

  task automatic test_zero_mask();
    clear_mon(); gaps = 1'b1; gdelay = 0;
    push_packet(4'b0000, 3, 1'b1);
    run_until_empty(100);
    n_checks++;
    if ({req_cycles, ov_cycles} !== {32'd0, 32'd0}) $display("FAIL zero_quiet: req=%0d ov=%0d want 0/0", req_cycles, ov_cycles);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== CW'(exp_drop)) $display("FAIL zero_drop_cnt: got %0d want %0d", drop_cnt, exp_drop);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_mon(); gaps = 1'b1; gdelay = 99;
    push_packet(4'($urandom_range(15, 1)), 3, 1'b1);
    run_until_empty(100);
    n_checks++;
    if ({req_cycles, ov_cycles} !== {32'(T), 32'd0}) $display("FAIL tmo_req_cycles: req=%0d ov=%0d want %0d/0", req_cycles, ov_cycles, T);
    else n_pass++;
    n_checks++;
    if ({timeout_cnt, drop_cnt} !== {CW'(exp_tmo), CW'(exp_drop)}) $display("FAIL tmo_counts: tmo=%0d drop=%0d want %0d/%0d", timeout_cnt, drop_cnt, exp_tmo, exp_drop);
    else n_pass++;
    clear_mon(); gdelay = T - 1;
    push_packet(4'($urandom_range(15, 1)), 3, 1'b1);
    run_until_empty(100);
    n_checks++;
    if (req_cycles !== T) $display("FAIL late_grant_req_cycles: got %0d want %0d", req_cycles, T);
    else n_pass++;
    compare_stream("late_grant");
    n_checks++;
    if ({timeout_cnt, pkt_cnt} !== {CW'(exp_tmo), CW'(exp_pkt)}) $display("FAIL late_grant_counts: tmo=%0d pkt=%0d want %0d/%0d", timeout_cnt, pkt_cnt, exp_tmo, exp_pkt);
    else n_pass++;
  endtask

  task automatic test_stray();
    beat_t b;
    clear_mon(); gaps = 1'b1; ordy_mode = 2; gdelay = $urandom_range(3, 0);
    b.d = $urandom; b.sop = 1'b0; b.eop = 1'b1;
    fifo_q.push_back(b);
    push_packet(4'b0001, 1, 1'b1);
    run_until_empty(100);
    ordy_mode = 0;
    n_checks++;
    if (stray_pulses !== 1) $display("FAIL stray_pulses: got %0d want 1", stray_pulses);
    else n_pass++;
    compare_stream("stray");
    n_checks++;
    if (pkt_cnt !== CW'(exp_pkt)) $display("FAIL stray_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_mon(); gaps = 1'b0; ordy_mode = 0; gdelay = 0; spur = 1'b1;
    push_packet(4'($urandom_range(15, 1)), 2, 1'b1);
    push_packet(4'($urandom_range(15, 1)), 3, 1'b1);
    run_until_empty(100);
    spur = 1'b0;
    compare_stream("b2b");
    n_checks++;
    if (req_rise_q.size() < 2 || eop_cyc_q.size() < 1 || req_rise_q[1] !== eop_cyc_q[0] + 2)
      $display("FAIL b2b_req_gap: got rise %0d want %0d", (req_rise_q.size() < 2) ? -1 : req_rise_q[1], (eop_cyc_q.size() < 1) ? -1 : eop_cyc_q[0] + 2);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int k = 0;
    clear_mon(); gaps = 1'b0; ordy_mode = 0; gdelay = 1;
    push_packet(4'($urandom_range(15, 1)), 5, 1'b0);
    while (obs_q.size() < 2 && k < 50) begin
      step();
      k++;
    end
    rst_n = 1'b0;
    exp_pkt = 0; exp_drop = 0; exp_tmo = 0;
    #1;
    n_checks++;
    if ({port_req, port_dst, out_valid, in_ready, out_eop, stray_err, pkt_cnt, drop_cnt, timeout_cnt} !== '0 || k >= 50)
      $display("FAIL midreset_outputs: got %b (wait %0d) want all zero",
               {port_req, port_dst, out_valid, in_ready, out_eop, stray_err, pkt_cnt, drop_cnt, timeout_cnt}, k);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_send = 1'b0; req_run = 0; prev_req = 1'b0;
    clear_mon(); gdelay = 0;
    push_packet(4'($urandom_range(15, 1)), 2, 1'b1);
    run_until_empty(100);
    n_checks++;
    if (stray_pulses !== 3) $display("FAIL midreset_strays: got %0d want 3", stray_pulses);
    else n_pass++;
    compare_stream("after_reset");
    n_checks++;
    if (pkt_cnt !== CW'(exp_pkt)) $display("FAIL after_reset_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    clear_mon(); gaps = 1'b0; gdelay = 0;
    for (int i = 0; i < CMAX + 1; i++) push_packet(4'b0000, 1, 1'b1);
    run_until_empty(200);
    n_checks++;
    if (drop_cnt !== CW'(exp_drop)) $display("FAIL drop_saturate: got %0d want %0d", drop_cnt, exp_drop);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_zero_mask();
    test_timeout();
    test_stray();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
